// File: rtl/id_imm_ctrl.sv
// Decode-stage controller for the immediate extender: classifies each fetched
// opcode into an immediate format and presents the beat through a registered
// ID stage with an optional one-entry skid buffer.

package params_pkg;

   typedef enum logic [2:0] {
      I_ALU_TYPE   = 3'd0,
      I_SHIFT_TYPE = 3'd1,
      S_TYPE       = 3'd2,
      B_TYPE       = 3'd3,
      U_TYPE       = 3'd4,
      J_TYPE       = 3'd5,
      CSR_TYPE     = 3'd6
   } imm_ext_op_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Everything that travels with a beat except the pc, whose width is a parameter.
   typedef struct packed {
      logic [31:0] insn;
      imm_ext_op_t op;
      logic        has_imm;
      logic        illegal;
   } id_beat_t;

   localparam id_beat_t BEAT_RST = '{insn: '0, op: I_ALU_TYPE, has_imm: 1'b0, illegal: 1'b0};

endpackage

module id_imm_ctrl
   import params_pkg::*;
#(
   parameter int unsigned PC_W    = 32,
   parameter bit          SKID_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [31:0]       insn_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic              flush_i,
   output logic              id_valid_o,
   input  logic              ex_ready_i,
   output logic [31:0]       insn_o,
   output logic [PC_W-1:0]   pc_o,
   output imm_ext_op_t       imm_ext_op_o,
   output logic              has_imm_o,
   output logic              illegal_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e            state_q;
   logic              valid_q;
   logic              rdy_q;
   id_beat_t          main_q, skid_q;
   logic [PC_W-1:0]   main_pc_q, skid_pc_q;
   id_beat_t          beat_d;
   logic              in_fire, out_fire;

   // With the skid entry, ready is a flop; without it, a stalled beat is only
   // replaced when downstream takes the current one in the same cycle.
   assign if_ready_o = SKID_EN ? rdy_q : (!valid_q || ex_ready_i);
   assign in_fire    = if_valid_i && if_ready_o;
   assign out_fire   = valid_q && ex_ready_i;

   // Classify the incoming opcode before it is captured.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      beat_d         = '{insn: insn_i, op: I_ALU_TYPE, has_imm: 1'b0, illegal: 1'b0};
      case (insn_i[6:0])
         OPC_OP_IMM: begin
            beat_d.has_imm = 1'b1;
            if (insn_i[14:12] == 3'b001 || insn_i[14:12] == 3'b101) beat_d.op = I_SHIFT_TYPE;
         end
         OPC_LOAD, OPC_JALR: beat_d.has_imm = 1'b1;
         OPC_STORE:  begin beat_d.op = S_TYPE; beat_d.has_imm = 1'b1; end
         OPC_BRANCH: begin beat_d.op = B_TYPE; beat_d.has_imm = 1'b1; end
         OPC_JAL:    begin beat_d.op = J_TYPE; beat_d.has_imm = 1'b1; end
         OPC_LUI, OPC_AUIPC: begin beat_d.op = U_TYPE; beat_d.has_imm = 1'b1; end
         OPC_SYSTEM: begin
            if (insn_i[14]) begin
               beat_d.op      = CSR_TYPE;
               beat_d.has_imm = 1'b1;
            end
         end
         OPC_OP:     ;
         default:    beat_d.illegal = 1'b1;
      endcase
   end

   // Occupancy FSM with registered valid/ready and the main/skid data registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_EMPTY;
         valid_q   <= 1'b0;
         rdy_q     <= 1'b1;
         // NOTE: data registers are reset too, because insn_o/pc_o/op are visible at reset.
         main_q    <= BEAT_RST;
         skid_q    <= BEAT_RST;
         main_pc_q <= '0;
         skid_pc_q <= '0;
      end else if (flush_i) begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_q   <= ST_FULL;
                  valid_q   <= 1'b1;
                  main_q    <= beat_d;
                  main_pc_q <= pc_i;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  main_q    <= beat_d;
                  main_pc_q <= pc_i;
               end else if (in_fire && SKID_EN) begin
                  state_q   <= ST_SKID;
                  rdy_q     <= 1'b0;
                  skid_q    <= beat_d;
                  skid_pc_q <= pc_i;
               end else if (out_fire) begin
                  state_q <= ST_EMPTY;
                  valid_q <= 1'b0;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  state_q   <= ST_FULL;
                  rdy_q     <= 1'b1;
                  main_q    <= skid_q;
                  main_pc_q <= skid_pc_q;
               end
            end
            default: begin
               state_q <= ST_EMPTY;
               valid_q <= 1'b0;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign id_valid_o   = valid_q;
   assign insn_o       = main_q.insn;
   assign pc_o         = main_pc_q;
   assign imm_ext_op_o = main_q.op;
   assign has_imm_o    = main_q.has_imm;
   assign illegal_o    = main_q.illegal;

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Bench for id_imm_ctrl: directed decode/skid/flush/reset cases on a skid
// instance, then random traffic on a skid and a no-skid instance checked
// against a beat-queue model.

module tb_id_imm_ctrl;
   import params_pkg::*;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] pc;
      imm_ext_op_t op;
      logic        has_imm;
      logic        illegal;
   } beat_t;

   logic clk;
   logic rst_n;

   // Index 0: SKID_EN=0 instance, index 1: SKID_EN=1 instance.
   logic        if_valid [2];
   logic        if_ready [2];
   logic [31:0] insn_in  [2];
   logic [31:0] pc_in    [2];
   logic        flush    [2];
   logic        id_valid [2];
   logic        ex_ready [2];
   logic [31:0] insn_out [2];
   logic [31:0] pc_out   [2];
   imm_ext_op_t op_out   [2];
   logic        has_imm  [2];
   logic        illegal  [2];

   int n_checks = 0;
   int n_errors = 0;

   // Model: per-instance FIFO of beats held inside the block.
   beat_t mem  [2][4];
   int    head [2];
   int    occ  [2];

   id_imm_ctrl #(.PC_W(32), .SKID_EN(1'b0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .if_valid_i(if_valid[0]), .if_ready_o(if_ready[0]),
      .insn_i(insn_in[0]), .pc_i(pc_in[0]), .flush_i(flush[0]),
      .id_valid_o(id_valid[0]), .ex_ready_i(ex_ready[0]),
      .insn_o(insn_out[0]), .pc_o(pc_out[0]), .imm_ext_op_o(op_out[0]),
      .has_imm_o(has_imm[0]), .illegal_o(illegal[0])
   );

   id_imm_ctrl #(.PC_W(32), .SKID_EN(1'b1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .if_valid_i(if_valid[1]), .if_ready_o(if_ready[1]),
      .insn_i(insn_in[1]), .pc_i(pc_in[1]), .flush_i(flush[1]),
      .id_valid_o(id_valid[1]), .ex_ready_i(ex_ready[1]),
      .insn_o(insn_out[1]), .pc_o(pc_out[1]), .imm_ext_op_o(op_out[1]),
      .has_imm_o(has_imm[1]), .illegal_o(illegal[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Expected decode from the opcode table.
   function automatic beat_t ref_beat(input logic [31:0] insn, input logic [31:0] pc);
      beat_t      r;
      logic [6:0] opc;
      logic [2:0] f3;
      opc       = insn[6:0];
      f3        = insn[14:12];
      r.insn    = insn;
      r.pc      = pc;
      r.op      = I_ALU_TYPE;
      r.has_imm = 1'b1;
      r.illegal = 1'b0;
      if (opc == 7'h13) r.op = (f3[1:0] == 2'b01) ? I_SHIFT_TYPE : I_ALU_TYPE;
      else if (opc == 7'h03 || opc == 7'h67) r.op = I_ALU_TYPE;
      else if (opc == 7'h23) r.op = S_TYPE;
      else if (opc == 7'h63) r.op = B_TYPE;
      else if (opc == 7'h6F) r.op = J_TYPE;
      else if (opc == 7'h37 || opc == 7'h17) r.op = U_TYPE;
      else if (opc == 7'h73) begin
         if (f3[2]) r.op = CSR_TYPE;
         else r.has_imm = 1'b0;
      end
      else if (opc == 7'h33) r.has_imm = 1'b0;
      else begin
         r.has_imm = 1'b0;
         r.illegal = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [6:0] pick_opcode(input int k, input logic [6:0] rnd);
      case (k)
         0: return 7'h13;  1: return 7'h03;  2: return 7'h67;  3: return 7'h23;
         4: return 7'h63;  5: return 7'h6F;  6: return 7'h37;  7: return 7'h17;
         8: return 7'h73;  9: return 7'h33;  10: return 7'h13;
         default: return rnd;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_beat(input string tag, input int i, input beat_t e);
      check({tag, "_insn"}, 64'(insn_out[i]), 64'(e.insn));
      check({tag, "_pc"}, 64'(pc_out[i]), 64'(e.pc));
      check({tag, "_op"}, 64'(op_out[i]), 64'(e.op));
      check({tag, "_imm"}, 64'(has_imm[i]), 64'(e.has_imm));
      check({tag, "_ill"}, 64'(illegal[i]), 64'(e.illegal));
   endtask

   task automatic drive1(input logic v, input logic [31:0] insn, input logic [31:0] pc);
      if_valid[1] = v;
      insn_in[1]  = insn;
      pc_in[1]    = pc;
   endtask

   initial begin
      logic        seen;
      logic        rdy_before;
      logic        in_f  [2];
      logic        out_f [2];
      logic        fl    [2];
      logic [31:0] rnd;
      beat_t       nb;

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if_valid[i] = 1'b0; insn_in[i] = '0; pc_in[i] = '0;
         flush[i] = 1'b0; ex_ready[i] = 1'b0;
         head[i] = 0; occ[i] = 0;
      end
      @(posedge clk); @(posedge clk); #1;
      check("rst_valid", 64'(id_valid[1]), 64'd0);
      check("rst_ready", 64'(if_ready[1]), 64'd1);
      check_beat("rst", 1, '{insn: 32'h0, pc: 32'h0, op: I_ALU_TYPE, has_imm: 1'b0, illegal: 1'b0});
      rst_n = 1'b1;

      // Decode cases streamed back-to-back with downstream always ready.
      ex_ready[1] = 1'b1;
      drive1(1'b1, 32'h00500093, 32'h1000); tick();
      check("addi_valid", 64'(id_valid[1]), 64'd1);
      check_beat("addi", 1, ref_beat(32'h00500093, 32'h1000));
      check("addi_op_lit", 64'(op_out[1]), 64'(I_ALU_TYPE));
      drive1(1'b1, 32'h00209093, 32'h1004); tick();
      check("slli_op", 64'(op_out[1]), 64'(I_SHIFT_TYPE));
      drive1(1'b1, 32'h0000006F, 32'h1008); tick();
      check("jal_op", 64'(op_out[1]), 64'(J_TYPE));
      drive1(1'b1, 32'h3400D073, 32'h100C); tick();
      check("csr_op", 64'(op_out[1]), 64'(CSR_TYPE));
      check("csr_imm", 64'(has_imm[1]), 64'd1);
      drive1(1'b1, 32'h0000007F, 32'h1010); tick();
      check("ill_flag", 64'(illegal[1]), 64'd1);
      check("ill_imm", 64'(has_imm[1]), 64'd0);
      check("ill_valid", 64'(id_valid[1]), 64'd1);
      drive1(1'b0, '0, '0); tick();
      check("drain_valid", 64'(id_valid[1]), 64'd0);

      // Back-to-back A,B with downstream stalled fills the skid entry.
      ex_ready[1] = 1'b0;
      drive1(1'b1, 32'h00500093, 32'h100); tick();
      drive1(1'b1, 32'h00112023, 32'h104); tick();
      drive1(1'b0, '0, '0);
      check("skid_ready", 64'(if_ready[1]), 64'd0);
      check_beat("skid_hold_a", 1, ref_beat(32'h00500093, 32'h100));
      tick();
      check("skid_ready2", 64'(if_ready[1]), 64'd0);
      check("skid_still_a", 64'(insn_out[1]), 64'h00500093);
      ex_ready[1] = 1'b1; tick();
      check("drain_b_valid", 64'(id_valid[1]), 64'd1);
      check_beat("drain_b", 1, ref_beat(32'h00112023, 32'h104));
      tick();
      check("drain_empty", 64'(id_valid[1]), 64'd0);
      check("drain_ready", 64'(if_ready[1]), 64'd1);

      // Flush with the skid entry full and a new beat offered.
      ex_ready[1] = 1'b0;
      drive1(1'b1, 32'h00500093, 32'h200); tick();
      drive1(1'b1, 32'h00112023, 32'h204); tick();
      drive1(1'b1, 32'h000012B7, 32'h208);
      flush[1] = 1'b1; tick();
      flush[1] = 1'b0;
      drive1(1'b0, '0, '0);
      check("flush_valid", 64'(id_valid[1]), 64'd0);
      check("flush_ready", 64'(if_ready[1]), 64'd1);
      ex_ready[1] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (id_valid[1]) seen = 1'b1;
      end
      check("flush_no_ghost", 64'(seen), 64'd0);

      // Asynchronous reset while the skid entry is full.
      ex_ready[1] = 1'b0;
      drive1(1'b1, 32'h00500093, 32'h300); tick();
      drive1(1'b1, 32'h0000006F, 32'h304); tick();
      drive1(1'b0, '0, '0);
      check("pre_rst_ready", 64'(if_ready[1]), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(id_valid[1]), 64'd0);
      check("arst_ready", 64'(if_ready[1]), 64'd1);
      check("arst_op", 64'(op_out[1]), 64'(I_ALU_TYPE));
      tick();
      check("arst_edge_valid", 64'(id_valid[1]), 64'd0);
      rst_n = 1'b1;

      // Random traffic on both instances against the beat-queue model.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if_valid[i] = ($urandom_range(0, 3) != 0);
            ex_ready[i] = ($urandom_range(0, 2) != 0);
            flush[i]    = ($urandom_range(0, 40) == 0);
            rnd         = $urandom();
            insn_in[i]  = {rnd[31:7], pick_opcode(int'($urandom_range(0, 12)), rnd[6:0])};
            pc_in[i]    = $urandom();
         end
         #1;
         rdy_before  = if_ready[1];
         ex_ready[1] = ~ex_ready[1];
         #1;
         check("ready_comb", 64'(if_ready[1]), 64'(rdy_before));
         ex_ready[1] = ~ex_ready[1];
         #1;
         for (int i = 0; i < 2; i++) begin
            check($sformatf("rnd%0d_valid", i), 64'(id_valid[i]), 64'(occ[i] > 0));
            if (i == 1) check("rnd1_ready", 64'(if_ready[i]), 64'(occ[i] < 2));
            else check("rnd0_ready", 64'(if_ready[i]), 64'(occ[i] == 0 || ex_ready[i]));
            if (occ[i] > 0) check_beat($sformatf("rnd%0d", i), i, mem[i][head[i]]);
            in_f[i]  = if_valid[i] && if_ready[i];
            out_f[i] = id_valid[i] && ex_ready[i];
            fl[i]    = flush[i];
         end
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (fl[i]) begin
               occ[i] = 0;
            end else begin
               if (out_f[i] && occ[i] > 0) begin
                  head[i] = (head[i] + 1) % 4;
                  occ[i]--;
               end
               if (in_f[i]) begin
                  nb = ref_beat(insn_in[i], pc_in[i]);
                  mem[i][(head[i] + occ[i]) % 4] = nb;
                  occ[i]++;
               end
            end
         end
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
